// File: rtl/datamem_stall_if.sv
// Request/response bundle between the MEM stage (master) and datamem_stall (slave).
interface datamem_stall_if;
    logic        Req;
    logic        WE;
    logic [1:0]  WidthSrc;
    logic        Unsigned;
    logic [31:0] A;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Done;
    logic        Busy;
    logic        Fault;

    modport master (output Req, WE, WidthSrc, Unsigned, A, WD,
                    input  RD, Done, Busy, Fault);
    modport slave  (input  Req, WE, WidthSrc, Unsigned, A, WD,
                    output RD, Done, Busy, Fault);
endinterface

// File: rtl/datamem_stall.sv
// Byte-addressable little-endian data memory with programmable wait states behind a
// Req/Done handshake; word/half/byte access with sign/zero extension and fault flagging.
module datamem_stall #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    datamem_stall_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH_WORDS * 4);
    localparam int         IW        = AW - 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    typedef struct packed {
        logic          we;
        logic [1:0]    width;
        logic          uns;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
    } access_t;

    state_e        state_q, state_d;
    logic          pend_q, pend_d;
    logic [3:0]    cnt_q, cnt_d;
    access_t       acc_q, acc_d;
    logic [31:0]   rd_q, rd_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [IW-1:0] word_idx;
    logic [31:0]   word_rd;
    logic [15:0]   half_rd;
    logic [7:0]    byte_rd;
    logic [31:0]   load_data;
    logic [31:0]   wr_data;
    logic [3:0]    byte_en;
    logic          acc_fault;
    logic          enter_done;
    logic          mem_we;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^bus.A[31:AW];

    assign word_idx = acc_q.addr[AW-1:2];
    assign word_rd  = mem[word_idx];
    assign half_rd  = acc_q.addr[1] ? word_rd[31:16] : word_rd[15:0];
    assign byte_rd  = word_rd[{acc_q.addr[1:0], 3'b000} +: 8];

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_fault = 1'b0;
        byte_en   = 4'b0000;
        wr_data   = acc_q.wd;
        load_data = word_rd;
        case (acc_q.width)
            2'b00: begin
                acc_fault = |acc_q.addr[1:0];
                byte_en   = 4'b1111;
            end
            2'b10: begin
                acc_fault = acc_q.addr[0];
                byte_en   = acc_q.addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{acc_q.wd[15:0]}};
                load_data = {{16{~acc_q.uns & half_rd[15]}}, half_rd};
            end
            2'b01: begin
                byte_en   = 4'b0001 << acc_q.addr[1:0];
                wr_data   = {4{acc_q.wd[7:0]}};
                load_data = {{24{~acc_q.uns & byte_rd[7]}}, byte_rd};
            end
            default: acc_fault = 1'b1;
        endcase
    end

    // Acceptance only registers the request; the FSM leaves IDLE one edge later,
    // so Done lands WAIT_CYCLES+1 edges after acceptance.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rd_d       = rd_q;
        fault_d    = fault_q;
        done_d     = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (acc_fault || WAIT_CYCLES == 0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else if (bus.Req) begin
                    pend_d      = 1'b1;
                    fault_d     = 1'b0;
                    acc_d.we    = bus.WE;
                    acc_d.width = bus.WidthSrc;
                    acc_d.uns   = bus.Unsigned;
                    acc_d.addr  = bus.A[AW-1:0];
                    acc_d.wd    = bus.WD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_done) begin
            done_d  = 1'b1;
            fault_d = acc_fault;
            rd_d    = (acc_fault || acc_q.we) ? 32'h0 : load_data;
        end
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: the array is deliberately left out of reset so it maps onto plain RAM; reset only blocks a pending commit.
    assign mem_we = enter_done && acc_q.we && !acc_fault && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            cnt_q   <= 4'd0;
            acc_q   <= '0;
            rd_q    <= 32'h0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign bus.RD    = rd_q;
    assign bus.Done  = done_q;
    assign bus.Busy  = busy_q;
    assign bus.Fault = fault_q;
endmodule
